router_input_arbiter: RTL and testbench

//  Input stage that sits directly upstream of the router's packet input. Buffers packets

---
 rtl/router_input_arbiter.sv | 177 +++++++++++++++++
 tb/tb_router_input_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_arbiter.sv
// -----------------------------------------------------------------------------
// router_input_arbiter
//
// Input stage placed directly upstream of the router's packet input. Packets
// from the local NI and the four neighbouring routers are buffered in per-port
// FIFOs. A round-robin arbiter forwards at most one packet per cycle, so
// simultaneous arrivals are serialised instead of being OR-combined.
// A packet is valid iff it is non-zero; idle links carry all zeros.
//
// Ports
//   i_clk        clock
//   i_srst       synchronous reset, active-high
//   i_apbPacket  packet from local NI          (port 0)
//   i_north      packet from north router      (port 1)
//   i_south      packet from south router      (port 2)
//   i_east       packet from east router       (port 3)
//   i_west       packet from west router       (port 4)
//   o_apbPacket  arbitrated packet (registered), zero when idle
//   o_grant      one-hot source port of o_apbPacket (registered), zero when idle
//   o_drop       per-port one-cycle pulse: incoming packet discarded (FIFO full)
//   o_full       per-port FIFO full, combinational from FIFO state
// -----------------------------------------------------------------------------
module router_input_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int PACKET_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_srst,
    input  logic [PACKET_WIDTH-1:0] i_apbPacket,
    input  logic [PACKET_WIDTH-1:0] i_north,
    input  logic [PACKET_WIDTH-1:0] i_south,
    input  logic [PACKET_WIDTH-1:0] i_east,
    input  logic [PACKET_WIDTH-1:0] i_west,
    output logic [PACKET_WIDTH-1:0] o_apbPacket,
    output logic [4:0]              o_grant,
    output logic [4:0]              o_drop,
    output logic [4:0]              o_full
);

    localparam int NPORTS = 5;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Adds an offset to a port index modulo the number of ports.
    function automatic logic [2:0] port_add(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end else begin
            sum = sum;
        end
        return sum[2:0];
    endfunction

    logic [PACKET_WIDTH-1:0] in_s   [NPORTS];
    logic [PACKET_WIDTH-1:0] mem_q  [NPORTS][FIFO_DEPTH];
    logic [AW-1:0]           wptr_q [NPORTS];
    logic [AW-1:0]           wptr_d [NPORTS];
    logic [AW-1:0]           rptr_q [NPORTS];
    logic [AW-1:0]           rptr_d [NPORTS];
    logic [CW-1:0]           cnt_q  [NPORTS];
    logic [CW-1:0]           cnt_d  [NPORTS];

    logic [2:0]              rr_q, rr_d;
    logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
    logic [4:0]              grant_q, grant_d;
    logic [4:0]              drop_q, drop_d;

    logic [4:0]              req_s, full_s, push_s, pop_s, accept_s;
    logic                    gnt_vld_s;
    logic [2:0]              gnt_idx_s;

    assign in_s[0] = i_apbPacket;
    assign in_s[1] = i_north;
    assign in_s[2] = i_south;
    assign in_s[3] = i_east;
    assign in_s[4] = i_west;

    // Per-port status: request (non-empty), full, and incoming valid packet.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            req_s[p]  = (cnt_q[p] != {CW{1'b0}});
            full_s[p] = (cnt_q[p] == DEPTH_C);
            push_s[p] = (in_s[p] != {PACKET_WIDTH{1'b0}});
        end
    end

    // Round-robin search starting at rr_q; iterating from the farthest offset
    // down lets the nearest requester overwrite and win.
    always_comb begin
        logic [2:0] cand;
        gnt_vld_s = 1'b0;
        gnt_idx_s = 3'd0;
        cand      = 3'd0;
        for (int off = NPORTS - 1; off >= 0; off--) begin
            cand = port_add(rr_q, 3'(off));
            if (req_s[cand]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = cand;
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
    end

    // FIFO next state: a push to a full FIFO is still accepted when the same
    // FIFO is popped this cycle (the freed head slot is the write slot).
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            pop_s[p]    = gnt_vld_s && (gnt_idx_s == 3'(p));
            accept_s[p] = push_s[p] && (!full_s[p] || pop_s[p]);
            drop_d[p]   = push_s[p] && full_s[p] && !pop_s[p];
            wptr_d[p]   = accept_s[p] ? (wptr_q[p] + AW'(1)) : wptr_q[p];
            rptr_d[p]   = pop_s[p]    ? (rptr_q[p] + AW'(1)) : rptr_q[p];
            case ({accept_s[p], pop_s[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + CW'(1);
                2'b01:   cnt_d[p] = cnt_q[p] - CW'(1);
                default: cnt_d[p] = cnt_q[p];
            endcase
        end
    end

    // Output and round-robin pointer next state.
    always_comb begin
        if (gnt_vld_s) begin
            pkt_d   = mem_q[gnt_idx_s][rptr_q[gnt_idx_s]];
            grant_d = 5'b00001 << gnt_idx_s;
            rr_d    = port_add(gnt_idx_s, 3'd1);
        end else begin
            pkt_d   = {PACKET_WIDTH{1'b0}};
            grant_d = 5'b00000;
            rr_d    = rr_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int p = 0; p < NPORTS; p++) begin
                wptr_q[p] <= {AW{1'b0}};
                rptr_q[p] <= {AW{1'b0}};
                cnt_q[p]  <= {CW{1'b0}};
            end
            rr_q    <= 3'd0;
            pkt_q   <= {PACKET_WIDTH{1'b0}};
            grant_q <= 5'b00000;
            drop_q  <= 5'b00000;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                wptr_q[p] <= wptr_d[p];
                rptr_q[p] <= rptr_d[p];
                cnt_q[p]  <= cnt_d[p];
            end
            rr_q    <= rr_d;
            pkt_q   <= pkt_d;
            grant_q <= grant_d;
            drop_q  <= drop_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (!i_srst && accept_s[p]) begin
                mem_q[p][wptr_q[p]] <= in_s[p];
            end
        end
    end

    assign o_apbPacket = pkt_q;
    assign o_grant     = grant_q;
    assign o_drop      = drop_q;
    assign o_full      = full_s;

endmodule

// File: tb/tb_router_input_arbiter.sv
module tb_router_input_arbiter;

    localparam int PW = 32;

    typedef struct {
        logic [PW-1:0] pkt;
        logic [4:0]    gnt;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [4:0] mask;
        int         cyc;
    } drop_t;

    logic          clk = 1'b0;
    logic          srst;
    logic [PW-1:0] in_a, in_n, in_s, in_e, in_w;
    logic [PW-1:0] o_pkt;
    logic [4:0]    o_grant, o_drop, o_full;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t  exp_q[$];
    drop_t drop_q[$];

    router_input_arbiter #(.FIFO_DEPTH(4), .PACKET_WIDTH(PW)) dut (
        .i_clk       (clk),
        .i_srst      (srst),
        .i_apbPacket (in_a),
        .i_north     (in_n),
        .i_south     (in_s),
        .i_east      (in_e),
        .i_west      (in_w),
        .o_apbPacket (o_pkt),
        .o_grant     (o_grant),
        .o_drop      (o_drop),
        .o_full      (o_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops expected packets/drops when the DUT presents them.
    always @(negedge clk) begin
        exp_t  e;
        drop_t d;
        if (o_grant != 5'd0 || o_pkt != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: cyc %0d got pkt %0h grant %b, expected no output", cyc, o_pkt, o_grant);
            end else begin
                e = exp_q.pop_front();
                if (o_pkt !== e.pkt || o_grant !== e.gnt || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL out_seq: got pkt %0h grant %b cyc %0d, expected pkt %0h grant %b cyc %0d",
                             o_pkt, o_grant, cyc, e.pkt, e.gnt, e.cyc);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL out_missing: cyc %0d got no output, expected pkt %0h grant %b", cyc, e.pkt, e.gnt);
        end

        if (o_drop != 5'd0) begin
            checks++;
            if (drop_q.size() == 0) begin
                errors++;
                $display("FAIL drop_unexpected: cyc %0d got drop %b, expected none", cyc, o_drop);
            end else begin
                d = drop_q.pop_front();
                if (o_drop !== d.mask || cyc != d.cyc) begin
                    errors++;
                    $display("FAIL drop_seq: got drop %b cyc %0d, expected drop %b cyc %0d", o_drop, cyc, d.mask, d.cyc);
                end
            end
        end else if (drop_q.size() > 0 && drop_q[0].cyc <= cyc) begin
            checks++;
            errors++;
            d = drop_q.pop_front();
            $display("FAIL drop_missing: cyc %0d got no drop, expected drop %b", cyc, d.mask);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [PW-1:0] a, n, s, e, w);
        in_a = a; in_n = n; in_s = s; in_e = e; in_w = w;
        step();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive('0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        drive('0, '0, '0, '0, '0);
        srst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [PW-1:0] pkt, input logic [4:0] gnt, input int c);
        exp_t e;
        e.pkt = pkt; e.gnt = gnt; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_drop(input logic [4:0] mask, input int c);
        drop_t d;
        d.mask = mask; d.cyc = c;
        drop_q.push_back(d);
    endtask

    initial begin
        int n;
        srst = 1'b1;
        in_a = '0; in_n = '0; in_s = '0; in_e = '0; in_w = '0;
        step();
        step();
        srst = 1'b0;

        // Reset state
        chk("rst_pkt",   o_pkt,          '0);
        chk("rst_grant", PW'(o_grant),   '0);
        chk("rst_drop",  PW'(o_drop),    '0);
        chk("rst_full",  PW'(o_full),    '0);

        // Single packet: appears exactly two cycles later, port 0
        do_reset();
        idle(3);
        n = cyc;
        push_exp(32'h5, 5'b00001, n + 2);
        drive(32'h5, '0, '0, '0, '0);
        idle(40);

        // Burst: all five ports in one cycle, served in port order
        do_reset();
        n = cyc;
        push_exp(32'h11, 5'b00001, n + 2);
        push_exp(32'h22, 5'b00010, n + 3);
        push_exp(32'h33, 5'b00100, n + 4);
        push_exp(32'h44, 5'b01000, n + 5);
        push_exp(32'h55, 5'b10000, n + 6);
        drive(32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
        idle(40);

        // Fairness: east/west held 20 cycles; grants alternate, drops alternate
        do_reset();
        n = cyc;
        for (int k = 2; k <= 28; k++) begin
            if (k % 2 == 0) push_exp(32'h8, 5'b01000, n + k);
            else            push_exp(32'h9, 5'b10000, n + k);
        end
        for (int k = 8; k <= 20; k++) begin
            if (k % 2 == 0) push_drop(5'b10000, n + k);
            else            push_drop(5'b01000, n + k);
        end
        for (int i = 0; i < 20; i++) drive('0, '0, '0, 32'h8, 32'h9);
        idle(40);

        // Full+pop on north (competing with south, port 0 idle)
        do_reset();
        n = cyc;
        for (int k = 2; k <= 16; k++) begin
            if (k % 2 == 0) push_exp(32'hA0 + 32'(k / 2),       5'b00010, n + k);
            else            push_exp(32'hB0 + 32'((k - 1) / 2), 5'b00100, n + k);
        end
        push_drop(5'b00100, n + 8);
        push_drop(5'b00010, n + 9);
        for (int k = 1; k <= 9; k++) begin
            if (k == 8) chk("full_ns", PW'(o_full), 32'h6);
            drive('0, 32'hA0 + 32'(k), (k <= 8) ? 32'hB0 + 32'(k) : 32'h0, '0, '0);
        end
        idle(40);

        // Reset mid-operation
        do_reset();
        n = cyc;
        push_exp(32'h101, 5'b00001, n + 2);
        push_exp(32'h201, 5'b00010, n + 3);
        for (int k = 1; k <= 3; k++)
            drive(32'h100 + 32'(k), 32'h200 + 32'(k), 32'h300 + 32'(k), 32'h400 + 32'(k), 32'h500 + 32'(k));
        srst = 1'b1;
        drive('0, '0, '0, '0, '0);
        srst = 1'b0;
        chk("mid_rst_pkt",   o_pkt,        '0);
        chk("mid_rst_grant", PW'(o_grant), '0);
        chk("mid_rst_drop",  PW'(o_drop),  '0);
        chk("mid_rst_full",  PW'(o_full),  '0);
        n = cyc;
        push_exp(32'h77, 5'b00100, n + 2);
        drive('0, '0, 32'h77, '0, '0);
        idle(40);

        // Zero inputs: outputs stay idle
        do_reset();
        for (int i = 0; i < 50; i++) begin
            chk("zero_pkt",   o_pkt,        '0);
            chk("zero_grant", PW'(o_grant), '0);
            step();
        end

        chk("exp_left",  32'(exp_q.size()),  '0);
        chk("drop_left", 32'(drop_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
